// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: address/sequence generator for an in-place radix-2 DIF FFT.
// Walks every stage, issues one butterfly per cycle (data addresses plus
// twiddle ROM address), then waits out the butterfly pipeline before the
// next stage. Optional bit-reversed unload is built when the macro
// FFT_BITREV_UNLOAD_EN is defined; otherwise rd_addr/rd_valid are tied to 0.
//
// Handshake: start is sampled only in IDLE; stall=1 in RUN (or UNLOAD) holds
// all counters and drops the valid for that edge, and has no effect
// elsewhere. busy covers start acceptance through the done pulse.
module fft_stage_ctrl #(
  parameter int N_LOG2   = 3,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [3:0]        stage,
  output logic              bf_valid,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2:0]   tw_addr,
  output logic              tw_valid,
  output logic [N_LOG2-1:0] rd_addr,
  output logic              rd_valid,
  output logic [2:0]        dbg_state_o
);

  localparam logic [3:0]        S_LAST = 4'(N_LOG2 - 1);
  localparam logic [3:0]        D_LAST = 4'(PIPE_LAT - 1);
  localparam logic [N_LOG2-2:0] B_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
`ifdef FFT_BITREV_UNLOAD_EN
    S_DONE  = 3'd3,
    S_UNLOAD = 3'd4
`else
    S_DONE  = 3'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          s_q, s_d;
  logic [N_LOG2-2:0]   b_q, b_d;
  logic [3:0]          dcnt_q, dcnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bfv_q, bfv_d;
  logic [N_LOG2-1:0]   a_q, a_d;
  logic [N_LOG2-1:0]   bb_q, bb_d;
  logic [N_LOG2:0]     tw_q, tw_d;

  logic [N_LOG2-1:0]   h, hmask, b_ext, j, a_calc, bb_calc, k;

`ifdef FFT_BITREV_UNLOAD_EN
  localparam logic [N_LOG2:0] I_END = (N_LOG2 + 1)'(1 << N_LOG2);
  logic [N_LOG2:0]     i_q, i_d;
  logic                rdv_q, rdv_d;
  logic [N_LOG2-1:0]   rda_q, rda_d;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int n = 0; n < N_LOG2; n++) r[n] = v[N_LOG2-1-n];
    return r;
  endfunction
`endif

  // Butterfly address math for (s_q, b_q); h is a power of two so g/j are masks.
  always_comb begin
    h       = N_LOG2'(1) << (S_LAST - s_q);
    hmask   = h - N_LOG2'(1);
    b_ext   = {1'b0, b_q};
    j       = b_ext & hmask;
    a_calc  = ((b_ext & ~hmask) << 1) | j;
    bb_calc = a_calc + h;
    k       = j << s_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    dcnt_d  = dcnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bfv_d   = 1'b0;
    a_d     = a_q;
    bb_d    = bb_q;
    tw_d    = tw_q;
`ifdef FFT_BITREV_UNLOAD_EN
    i_d     = i_q;
    rdv_d   = 1'b0;
    rda_d   = rda_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          s_d     = 4'd0;
          b_d     = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          bfv_d = 1'b1;
          a_d   = a_calc;
          bb_d  = bb_calc;
          tw_d  = {1'b1, k};
          if (b_q == B_LAST) begin
            b_d     = '0;
            dcnt_d  = 4'd0;
            state_d = S_DRAIN;
          end else begin
            b_d = b_q + (N_LOG2 - 1)'(1);
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          if (s_q < S_LAST) begin
            s_d     = s_q + 4'd1;
            state_d = S_RUN;
          end else begin
`ifdef FFT_BITREV_UNLOAD_EN
            i_d     = '0;
            state_d = S_UNLOAD;
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
`endif
          end
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
`ifdef FFT_BITREV_UNLOAD_EN
      S_UNLOAD: begin
        if (i_q == I_END) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (!stall) begin
          rdv_d = 1'b1;
          rda_d = bitrev(i_q[N_LOG2-1:0]);
          i_d   = i_q + (N_LOG2 + 1)'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset clears everything and aborts a transform.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      b_q     <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bfv_q   <= 1'b0;
      a_q     <= '0;
      bb_q    <= '0;
      tw_q    <= '0;
`ifdef FFT_BITREV_UNLOAD_EN
      i_q     <= '0;
      rdv_q   <= 1'b0;
      rda_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bfv_q   <= bfv_d;
      a_q     <= a_d;
      bb_q    <= bb_d;
      tw_q    <= tw_d;
`ifdef FFT_BITREV_UNLOAD_EN
      i_q     <= i_d;
      rdv_q   <= rdv_d;
      rda_q   <= rda_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign stage       = s_q;
  assign bf_valid    = bfv_q;
  assign tw_valid    = bfv_q;
  assign addr_a      = a_q;
  assign addr_b      = bb_q;
  assign tw_addr     = tw_q;
  assign dbg_state_o = state_q;
`ifdef FFT_BITREV_UNLOAD_EN
  assign rd_addr  = rda_q;
  assign rd_valid = rdv_q;
`else
  assign rd_addr  = '0;
  assign rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: scoreboard of expected butterflies, unload
// elements and done pulses (with their edge offsets from start acceptance)
// built from the FFT index rules, plus a directed N=4 / PIPE_LAT=1 instance.
module tb_fft_stage_ctrl;
  localparam int NL = 3;
  localparam int P  = 4;
  localparam int N  = 1 << NL;
  localparam int W  = 2 + 16 + 4 + NL + NL + (NL + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;
  always #5 clk = ~clk;

  logic          busy, done, bf_valid, tw_valid, rd_valid;
  logic [3:0]    stage;
  logic [NL-1:0] addr_a, addr_b, rd_addr;
  logic [NL:0]   tw_addr;
  logic [2:0]    dbg_state;

  fft_stage_ctrl #(.N_LOG2(NL), .PIPE_LAT(P)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy), .done(done), .stage(stage), .bf_valid(bf_valid),
    .addr_a(addr_a), .addr_b(addr_b), .tw_addr(tw_addr), .tw_valid(tw_valid),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .dbg_state_o(dbg_state)
  );

  // small instance: N=4, PIPE_LAT=1
  logic       start2 = 1'b0;
  logic       busy2, done2, bfv2, twv2, rdv2;
  logic [3:0] stage2;
  logic [1:0] a2, b2, rda2;
  logic [2:0] tw2, dbg2;

  fft_stage_ctrl #(.N_LOG2(2), .PIPE_LAT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stall(1'b0),
    .busy(busy2), .done(done2), .stage(stage2), .bf_valid(bfv2),
    .addr_a(a2), .addr_b(b2), .tw_addr(tw2), .tw_valid(twv2),
    .rd_addr(rda2), .rd_valid(rdv2), .dbg_state_o(dbg2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  int t0 = 0;
  int next_t0 = 0;
  logic [W-1:0] exp_q[$];
  logic stall_pat[0:511];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pack(input int kind, input int off, input int s,
                                        input int a, input int b, input int tw);
    return {2'(kind), 16'(off), 4'(s), NL'(a), NL'(b), (NL + 1)'(tw)};
  endfunction

  task automatic gen_pat(input int pct);
    for (int i = 0; i < 512; i++) stall_pat[i] = ($urandom_range(0, 99) < pct);
  endtask

  // reference model: push every expected event of one transform
  task automatic model(output int done_off);
    int t;
    t = 1;
    for (int s = 0; s < NL; s++) begin
      int h;
      h = N >> (s + 1);
      for (int b = 0; b < N / 2; b++) begin
        int g, j, a;
        while (stall_pat[t] && t < 511) t++;
        g = b / h;
        j = b % h;
        a = 2 * h * g + j;
        exp_q.push_back(pack(0, t, s, a, a + h, N + (j << s)));
        t++;
      end
      t += P;
    end
`ifdef FFT_BITREV_UNLOAD_EN
    for (int i = 0; i < N; i++) begin
      int r;
      r = 0;
      for (int n = 0; n < NL; n++) r = r * 2 + ((i >> n) & 1);
      while (stall_pat[t] && t < 511) t++;
      exp_q.push_back(pack(2, t, 0, r, 0, 0));
      t++;
    end
    done_off = t;
`else
    done_off = t - 1;
`endif
    exp_q.push_back(pack(1, done_off, 0, 0, 0, 0));
  endtask

  task automatic expect_pop(input string name, input logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: unexpected output %0h, nothing expected (cycle %0d)", name, got, cyc);
    end else begin
      check(name, 64'(got), 64'(exp_q.pop_front()));
    end
  endtask

  // monitor: compares every presented output against the scoreboard
  always @(posedge clk) begin
    #1;
    if (bf_valid) begin
      expect_pop("butterfly", pack(0, cyc - t0, stage, addr_a, addr_b, tw_addr));
      check("tw_valid", 64'(tw_valid), 64'd1);
      check("busy_during_issue", 64'(busy), 64'd1);
    end
    if (rd_valid) expect_pop("unload", pack(2, cyc - t0, 0, rd_addr, 0, 0));
    if (done) begin
      expect_pop("done", pack(1, cyc - t0, 0, 0, 0, 0));
      check("busy_at_done", 64'(busy), 64'd0);
    end
  end

  // driver: one transform; keep holds start high into the next one
  task automatic run_transform(input bit keep, input int abort_off);
    int d;
    model(d);
    if (start) t0 = next_t0;
    else begin
      @(negedge clk);
      start = 1'b1;
      t0 = cyc + 1;
    end
    for (int t = 1; t <= d; t++) begin
      do @(negedge clk); while (cyc < t0 + t - 1);
      if (!keep) start = 1'b0;
      stall = stall_pat[t];
      if (t == abort_off) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        start = 1'b0;
        check("abort_outputs",
              64'({busy, done, bf_valid, tw_valid, rd_valid, stage, addr_a, addr_b, tw_addr, rd_addr}),
              64'd0);
        exp_q.delete();
        repeat (20) begin
          @(negedge clk);
          check("abort_quiet", 64'({done, busy, bf_valid}), 64'd0);
        end
        return;
      end
    end
    @(negedge clk);
    stall = 1'b0;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    if (keep) next_t0 = t0 + d + 2;
    else repeat (2) @(negedge clk);
  endtask

  // directed expectations for the N=4, PIPE_LAT=1 instance: {valid, a, b, tw}
  function automatic logic [7:0] exp_small(input int off);
    case (off)
      1: return {1'b1, 2'd0, 2'd2, 3'd4};
      2: return {1'b1, 2'd1, 2'd3, 3'd5};
      4: return {1'b1, 2'd0, 2'd1, 3'd4};
      5: return {1'b1, 2'd2, 2'd3, 3'd4};
      default: return 8'd0;
    endcase
  endfunction

`ifdef FFT_BITREV_UNLOAD_EN
  localparam int DONE2 = 11;
`else
  localparam int DONE2 = 6;
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t2;
    logic [7:0] e;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({busy, done, bf_valid, tw_valid, rd_valid, stage, addr_a, addr_b, tw_addr, rd_addr}),
          64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // plain transform, no stall
    gen_pat(0);
    run_transform(1'b0, 0);

    // 3-cycle stall on stage 1 butterfly 2 (edges T0+11..T0+13)
    gen_pat(0);
    stall_pat[11] = 1'b1;
    stall_pat[12] = 1'b1;
    stall_pat[13] = 1'b1;
    run_transform(1'b0, 0);

    // random stall, including stalls during drain
    for (int r = 0; r < 4; r++) begin
      gen_pat(30);
      run_transform(1'b0, 0);
    end

    // start held high: back-to-back transforms
    gen_pat(0);
    run_transform(1'b1, 0);
    gen_pat(20);
    run_transform(1'b1, 0);
    gen_pat(0);
    run_transform(1'b0, 0);

    // reset during stage-1 drain, then a full transform
    gen_pat(0);
    run_transform(1'b0, 14);
    gen_pat(0);
    run_transform(1'b0, 0);

    // N=4, PIPE_LAT=1 directed sequence
    @(negedge clk);
    start2 = 1'b1;
    t2 = cyc + 1;
    @(negedge clk);
    start2 = 1'b0;
    for (int off = 1; off <= 12; off++) begin
      @(negedge clk);
      e = exp_small(off);
      check("n4_bf_valid", 64'(bfv2), 64'(e[7]));
      if (e[7]) check("n4_addr", 64'({a2, b2, tw2}), 64'(e[6:0]));
      check("n4_done", 64'(done2), 64'(off == DONE2));
      if (cyc != t2 + off) check("n4_timing", 64'(cyc), 64'(t2 + off));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
